// File: rtl/lcd_cfah_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cfah_ctrl
// Purpose  : Character-LCD write sequencer behind a command FIFO, with optional
//            busy-flag polling (macro LCD_CFAH_CTRL_BUSY_POLL_EN).
// Revision : 1.0
// ============================================================================
module lcd_cfah_ctrl #(
  parameter int G_FIFO_DEPTH      = 4,
  parameter int G_SETUP_CYCLES    = 2,
  parameter int G_EN_CYCLES       = 12,
  parameter int G_POLL_MAX        = 255,
  parameter int G_CMD_WAIT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_wdata,
  input  logic       i_wrs,
  input  logic       i_wval,
  output logic       o_wrdy,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_data_oe,
  input  logic [7:0] i_lcd_data,
  output logic       o_lcd_on,
  output logic       o_busy,
  output logic       o_timeout,
  input  logic       i_clr_timeout
);

  localparam int C_AW = $clog2(G_FIFO_DEPTH);
  localparam int C_SE = (G_SETUP_CYCLES > G_EN_CYCLES) ? G_SETUP_CYCLES : G_EN_CYCLES;
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
  localparam int C_CMAX = C_SE;
`else
  localparam int C_CMAX = (C_SE > G_CMD_WAIT_CYCLES) ? C_SE : G_CMD_WAIT_CYCLES;
`endif
  localparam int C_CW = $clog2(C_CMAX + 1);
  localparam logic [C_CW-1:0] C_CNT_ONE    = C_CW'(1);
  localparam logic [C_CW-1:0] C_SETUP_LAST = C_CW'(G_SETUP_CYCLES - 1);
  localparam logic [C_CW-1:0] C_EN_LAST    = C_CW'(G_EN_CYCLES - 1);
  localparam logic [C_AW:0]   C_PTR_ONE    = (C_AW + 1)'(1);
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
  localparam int C_PW = $clog2(G_POLL_MAX + 1);
  localparam logic [C_PW-1:0] C_POLL_MAX = C_PW'(G_POLL_MAX);
  localparam logic [C_PW-1:0] C_POLL_ONE = C_PW'(1);
`else
  localparam logic [C_CW-1:0] C_WAIT_LAST = C_CW'(G_CMD_WAIT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_SETUP = 3'd1,
    S_W_EN    = 3'd2,
    S_W_HOLD  = 3'd3,
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
    S_R_SETUP = 3'd4,
    S_R_EN    = 3'd5,
    S_R_HOLD  = 3'd6
`else
    S_WAIT    = 3'd7
`endif
  } state_e;

  // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [8:0]    mem_q [G_FIFO_DEPTH];
  logic [C_AW:0] wptr_q, rptr_q;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [8:0]    fifo_head;

  state_e          state_q;
  logic [C_CW-1:0] cnt_q;
  logic            en_q, rs_q, rw_q, oe_q, on_q;
  logic [7:0]      data_q;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[C_AW] != rptr_q[C_AW]) &&
                      (wptr_q[C_AW-1:0] == rptr_q[C_AW-1:0]);
  assign fifo_head  = mem_q[rptr_q[C_AW-1:0]];
  assign fifo_push  = i_wval & o_wrdy;
  assign fifo_pop   = (state_q == S_IDLE) & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (fifo_push) wptr_q <= wptr_q + C_PTR_ONE;
      if (fifo_pop)  rptr_q <= rptr_q + C_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wptr_q[C_AW-1:0]] <= {i_wrs, i_wdata};
  end

`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
  logic [C_PW-1:0] poll_q;
  logic            busy_flag_q;
  logic            timeout_q;
  logic            unused_sig;
  assign unused_sig = ^{i_lcd_data[6:0], (G_CMD_WAIT_CYCLES > 0)};
  assign o_timeout  = timeout_q;
`else
  logic unused_sig;
  assign unused_sig = ^{i_lcd_data, i_clr_timeout, (G_POLL_MAX > 0)};
  assign o_timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      data_q  <= 8'h00;
      on_q    <= 1'b0;
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
      poll_q      <= '0;
      busy_flag_q <= 1'b0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      on_q <= 1'b1;
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
      // A timeout raised later in this block overrides the clear.
      if (i_clr_timeout) timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_q <= S_W_SETUP;
            rs_q    <= fifo_head[8];
            data_q  <= fifo_head[7:0];
            rw_q    <= 1'b0;
            oe_q    <= 1'b1;
            cnt_q   <= '0;
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
            poll_q  <= '0;
`endif
          end
        end
        S_W_SETUP: begin
          if (cnt_q == C_SETUP_LAST) begin
            state_q <= S_W_EN;
            en_q    <= 1'b1;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + C_CNT_ONE;
        end
        S_W_EN: begin
          if (cnt_q == C_EN_LAST) begin
            state_q <= S_W_HOLD;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + C_CNT_ONE;
        end
        S_W_HOLD: begin
          if (cnt_q == C_SETUP_LAST) begin
            cnt_q <= '0;
            oe_q  <= 1'b0;
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
            state_q <= S_R_SETUP;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
`else
            state_q <= S_WAIT;
`endif
          end else cnt_q <= cnt_q + C_CNT_ONE;
        end
`ifdef LCD_CFAH_CTRL_BUSY_POLL_EN
        S_R_SETUP: begin
          if (cnt_q == C_SETUP_LAST) begin
            state_q <= S_R_EN;
            en_q    <= 1'b1;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + C_CNT_ONE;
        end
        S_R_EN: begin
          if (cnt_q == C_EN_LAST) begin
            state_q     <= S_R_HOLD;
            en_q        <= 1'b0;
            cnt_q       <= '0;
            busy_flag_q <= i_lcd_data[7];
            poll_q      <= poll_q + C_POLL_ONE;
          end else cnt_q <= cnt_q + C_CNT_ONE;
        end
        S_R_HOLD: begin
          if (cnt_q == C_SETUP_LAST) begin
            cnt_q <= '0;
            if (busy_flag_q && (poll_q < C_POLL_MAX)) begin
              state_q <= S_R_SETUP;
            end else begin
              state_q <= S_IDLE;
              rw_q    <= 1'b0;
              if (busy_flag_q) timeout_q <= 1'b1;
            end
          end else cnt_q <= cnt_q + C_CNT_ONE;
        end
`else
        S_WAIT: begin
          if (cnt_q == C_WAIT_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + C_CNT_ONE;
        end
`endif
        default: begin
          state_q <= S_IDLE;
          en_q    <= 1'b0;
          rw_q    <= 1'b0;
          oe_q    <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_wrdy        = on_q & ~fifo_full;
  assign o_lcd_on      = on_q;
  assign o_lcd_rs      = rs_q;
  assign o_lcd_rw      = rw_q;
  assign o_lcd_en      = en_q;
  assign o_lcd_data    = data_q;
  assign o_lcd_data_oe = oe_q;
  assign o_busy        = (state_q != S_IDLE) | ~fifo_empty;

endmodule
`default_nettype wire

// File: doc/lcd_cfah_ctrl.md
LCD_CFAH_CTRL -- requirements
Module: lcd_cfah_ctrl

Interface
REQ-001 SHALL have parameter G_FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter G_SETUP_CYCLES, default 2, cycles of rs/rw/data setup before EN rise and hold after EN fall.
REQ-003 SHALL have parameter G_EN_CYCLES, default 12, cycles EN held high per access.
REQ-004 SHALL have parameter G_POLL_MAX, default 255, maximum busy-flag reads per command before timeout.
REQ-005 SHALL have parameter G_CMD_WAIT_CYCLES, default 2000, fixed post-write wait when polling is compiled out.
REQ-006 SHALL have ports, in this order:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_wdata  in  8  command/data byte to push.
- i_wrs  in  1  register select for pushed byte (0 = instruction, 1 = data).
- i_wval  in  1  push request.
- o_wrdy  out  1  FIFO not full; a push occurs when i_wval & o_wrdy.
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD RW (1 = read).
- o_lcd_en  out  1  LCD EN strobe.
- o_lcd_data  out  8  LCD data out.
- o_lcd_data_oe  out  1  tristate enable for o_lcd_data (1 = drive).
- i_lcd_data  in  8  LCD data in (bit 7 = busy flag).
- o_lcd_on  out  1  LCD backlight/power, 1 once out of reset.
- o_busy  out  1  1 when FIFO non-empty or FSM not IDLE.
- o_timeout  out  1  sticky timeout flag.
- i_clr_timeout  in  1  clears o_timeout.

Function
REQ-007 SHALL buffer {i_wrs, i_wdata} in a G_FIFO_DEPTH FIFO; o_wrdy = not full; a push while full SHALL be impossible (o_wrdy low), and the entry freed by a pop SHALL be pushable from the next cycle.
REQ-008 SHALL implement FSM states IDLE, W_SETUP, W_EN, W_HOLD, R_SETUP, R_EN, R_HOLD, WAIT.
REQ-009 IDLE: on FIFO non-empty, pop one entry and go to W_SETUP next cycle; otherwise remain.
REQ-010 W_SETUP: rs = entry rs, rw = 0, data = entry byte, oe = 1, en = 0, for G_SETUP_CYCLES cycles, then W_EN.
REQ-011 W_EN: en = 1 for exactly G_EN_CYCLES cycles with rs/rw/data stable, then W_HOLD.
REQ-012 W_HOLD: en = 0, data/oe still driven for G_SETUP_CYCLES cycles, then R_SETUP (polling) or WAIT (no polling).
REQ-013 R_SETUP: rs = 0, rw = 1, oe = 0, en = 0, for G_SETUP_CYCLES cycles, then R_EN.
REQ-014 R_EN: en = 1 for G_EN_CYCLES cycles; i_lcd_data[7] SHALL be sampled on the last cycle of EN high.
REQ-015 R_HOLD: en = 0 for G_SETUP_CYCLES cycles; then, if sampled flag = 0, go to IDLE; if 1 and poll count < G_POLL_MAX, go to R_SETUP; if poll count = G_POLL_MAX, set o_timeout and go to IDLE.
REQ-016 Poll count SHALL be cleared on each W_SETUP entry, SHALL increment per completed read, and SHALL be $clog2(G_POLL_MAX+1) bits wide.
REQ-017 WAIT: en = 0, oe = 0, for G_CMD_WAIT_CYCLES cycles, then IDLE.
REQ-018 In IDLE: en = 0, rw = 0, oe = 0, rs and data hold their last values.
REQ-019 A timeout SHALL NOT flush the FIFO; the next entry SHALL proceed normally.
REQ-020 When i_clr_timeout and a new timeout occur in the same cycle, set SHALL win.
REQ-021 o_busy SHALL be combinational: (state != IDLE) | FIFO non-empty.
REQ-022 oe and rw SHALL never both be 1.
REQ-023 EN SHALL never rise in the same cycle that rs, rw or data changes.

Reset
REQ-024 On rst = 1 at a clock edge: state = IDLE, FIFO flushed, counters = 0, o_lcd_en = 0, o_lcd_rs = 0, o_lcd_rw = 0, o_lcd_data = 0x00, o_lcd_data_oe = 0, o_timeout = 0, o_lcd_on = 0, o_wrdy = 0.
REQ-025 After rst deasserts: o_wrdy = 1 and o_lcd_on = 1 from the first cycle.
REQ-026 Reset mid-access SHALL drop EN to 0 at that edge, abandoning the access.

Configuration
REQ-027 Macro LCD_CFAH_CTRL_BUSY_POLL_EN SHALL control busy polling:
- Defined: R_SETUP/R_EN/R_HOLD polling per REQ-012..016; WAIT unused.
- Undefined: no read states or poll counter are synthesised; W_HOLD -> WAIT; o_timeout is tied to 0; i_lcd_data is ignored.

Verification
REQ-028 Bench SHALL cover (polling defined, emulator busy flag duration 20 cycles): push 0x38 rs=0 -> one 12-cycle EN pulse with data 0x38, rs=0, rw=0; then read pulses until busy = 0; o_busy low afterwards.
REQ-029 Bench SHALL cover: push 0x41 rs=1 -> emulator o_rdata = 0x41 with rdata_val; rs = 1 during the write pulse.
REQ-030 Bench SHALL cover: push 5 entries back-to-back (depth 4) -> o_wrdy low after the 4th entry is held; all 5 bytes reach the emulator in order.
REQ-031 Bench SHALL cover: emulator forced busy (i_wdata_sel = 1, i_wdata = 0x80), G_POLL_MAX = 3 -> exactly 3 read pulses, then o_timeout = 1; i_clr_timeout -> o_timeout = 0.
REQ-032 Bench SHALL cover: rst asserted during W_EN -> o_lcd_en = 0 at the next edge, o_busy = 0, FIFO empty.
REQ-033 Bench SHALL cover (polling undefined): push 0x01 -> write pulse, then no read pulse, and the next EN rise no earlier than G_CMD_WAIT_CYCLES + G_SETUP_CYCLES after W_HOLD ends.
